// File: rtl/mem_defines.sv
// Shared memory-subsystem definitions: AXI encodings, line geometry helpers and
// the state type of the AXI line master.
package mem_defines;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Byte-offset bits inside one line for the default 4 x 32-bit geometry.
   localparam int LINE_OFFSET_BITS = 4;

   function automatic int line_offset_bits(input int line_words, input int data_width);
      return $clog2(line_words * (data_width / 8));
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_B,
      ST_DONE
   } axi_line_state_t;

endpackage

// File: rtl/axi_line_master.sv
// AXI4 master turning cache-line fill/writeback requests into single INCR bursts,
// one transaction in flight, with the full line exchanged as flat buses.
module axi_line_master
   import mem_defines::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int ID_WIDTH   = 8,
   parameter int AXI_ID     = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic                                req_write,
   input  logic [ADDR_WIDTH-1:0]               req_addr,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0]    req_wdata,
   input  logic [LINE_WORDS*DATA_WIDTH/8-1:0]  req_wstrb,
   output logic                                resp_valid,
   output logic [LINE_WORDS*DATA_WIDTH-1:0]    resp_rdata,
   output logic                                resp_err,
   output logic [ID_WIDTH-1:0]                 m_axi_awid,
   output logic [ADDR_WIDTH-1:0]               m_axi_awaddr,
   output logic [7:0]                          m_axi_awlen,
   output logic [2:0]                          m_axi_awsize,
   output logic [1:0]                          m_axi_awburst,
   output logic                                m_axi_awlock,
   output logic [3:0]                          m_axi_awcache,
   output logic [2:0]                          m_axi_awprot,
   output logic                                m_axi_awvalid,
   input  logic                                m_axi_awready,
   output logic [DATA_WIDTH-1:0]               m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]             m_axi_wstrb,
   output logic                                m_axi_wlast,
   output logic                                m_axi_wvalid,
   input  logic                                m_axi_wready,
   input  logic [ID_WIDTH-1:0]                 m_axi_bid,
   input  logic [1:0]                          m_axi_bresp,
   input  logic                                m_axi_bvalid,
   output logic                                m_axi_bready,
   output logic [ID_WIDTH-1:0]                 m_axi_arid,
   output logic [ADDR_WIDTH-1:0]               m_axi_araddr,
   output logic [7:0]                          m_axi_arlen,
   output logic [2:0]                          m_axi_arsize,
   output logic [1:0]                          m_axi_arburst,
   output logic                                m_axi_arlock,
   output logic [3:0]                          m_axi_arcache,
   output logic [2:0]                          m_axi_arprot,
   output logic                                m_axi_arvalid,
   input  logic                                m_axi_arready,
   input  logic [ID_WIDTH-1:0]                 m_axi_rid,
   input  logic [DATA_WIDTH-1:0]               m_axi_rdata,
   input  logic [1:0]                          m_axi_rresp,
   input  logic                                m_axi_rlast,
   input  logic                                m_axi_rvalid,
   output logic                                m_axi_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = $clog2(LINE_WORDS) + 1;
   localparam int IDX_WIDTH  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int OFF_BITS   = line_offset_bits(LINE_WORDS, DATA_WIDTH);

   localparam logic [CNT_WIDTH-1:0]  LAST_BEAT = CNT_WIDTH'(LINE_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
   localparam logic [7:0]            BURST_LEN = 8'(LINE_WORDS - 1);
   localparam logic [2:0]            BEAT_SIZE = 3'($clog2(STRB_WIDTH));

   axi_line_state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  err_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [IDX_WIDTH-1:0]  idx;
   logic [DATA_WIDTH-1:0] rbuf [LINE_WORDS];
   logic [DATA_WIDTH-1:0] wbuf [LINE_WORDS];
   logic [STRB_WIDTH-1:0] sbuf [LINE_WORDS];
   logic                  last_beat;
   logic                  unused_axi_ids;

   // Response IDs are never checked: only one burst is ever outstanding.
   assign unused_axi_ids = ^{m_axi_bid, m_axi_rid};

   assign idx       = cnt_q[IDX_WIDTH-1:0];
   assign last_beat = (cnt_q == LAST_BEAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = req_write ? ST_AW : ST_AR;
         end
         ST_AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_d = ST_R;
         end
         ST_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid && last_beat) state_d = ST_DONE;
         end
         ST_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_d = ST_W;
         end
         ST_W: begin
            m_axi_wvalid = 1'b1;
            m_axi_wlast  = last_beat;
            if (m_axi_wready && last_beat) state_d = ST_B;
         end
         ST_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_d = ST_DONE;
         end
         ST_DONE: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The fill buffer is cleared on every accept so a writeback completes with zero data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
         for (int i = 0; i < LINE_WORDS; i++) begin
            rbuf[i] <= '0;
            wbuf[i] <= '0;
            sbuf[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr & LINE_MASK;
                  err_q  <= 1'b0;
                  cnt_q  <= '0;
                  for (int i = 0; i < LINE_WORDS; i++) begin
                     rbuf[i] <= '0;
                     wbuf[i] <= req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                     sbuf[i] <= req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
                  end
               end
            end
            ST_R: begin
               if (m_axi_rvalid) begin
                  rbuf[idx] <= m_axi_rdata;
                  cnt_q     <= cnt_q + CNT_WIDTH'(1);
                  if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat))
                     err_q <= 1'b1;
               end
            end
            ST_W: begin
               if (m_axi_wready) cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            ST_B: begin
               if (m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      resp_rdata = '0;
      for (int i = 0; i < LINE_WORDS; i++)
         resp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rbuf[i];
   end

   assign resp_err      = err_q;

   assign m_axi_arid    = ID_WIDTH'(AXI_ID);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = BURST_LEN;
   assign m_axi_arsize  = BEAT_SIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;

   assign m_axi_awid    = ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = BURST_LEN;
   assign m_axi_awsize  = BEAT_SIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;

   assign m_axi_wdata   = wbuf[idx];
   assign m_axi_wstrb   = sbuf[idx];

endmodule
